// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage: default PC width,
//   the program-terminating HALT word, the fetch FSM state type and the
//   contents of the 16-entry branch offset table.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int         PC_W_DEFAULT      = 10;
  localparam logic [8:0] HALT_WORD_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  // Offsets are stored 16 bits wide and resized to the PC width at the point
  // of use, so a narrower PC simply wraps large offsets modulo 2**PC_W.
  localparam int LUT_W = 16;

  // Entry 0 is the rightmost element.
  localparam logic [15:0][LUT_W-1:0] BRANCH_LUT = {
    16'd200, 16'd100, 16'd10, 16'd64,   // 15..12
    16'd9,   16'd12,  16'd7,  16'd32,   // 11..8
    16'd5,   16'd16,  16'd3,  16'd8,    //  7..4
    16'd4,   16'd6,   16'd2,  16'd1     //  3..0
  };

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_branch_lut.sv
// -----------------------------------------------------------------------------
// branch_lut
//   Combinational branch offset table: maps the 4-bit index carried in a
//   branch instruction to an unsigned PC_W-bit offset magnitude. The sign
//   (forward/backward) is applied by the caller.
//
// Ports
//   idx_i     in   4      table index
//   offset_o  out  PC_W   unsigned offset magnitude
// -----------------------------------------------------------------------------
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [3:0]      idx_i,
  output logic [PC_W-1:0] offset_o
);

  assign offset_o = PC_W'(BRANCH_LUT[idx_i]);

endmodule : branch_lut

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage in front of the decoder. Owns the PC, addresses a
//   synchronous instruction ROM (one cycle read latency) and presents one
//   instruction per cycle with a valid flag. Taken branches are resolved with
//   a LUT offset and a software-set direction bit; the fetch already in flight
//   is squashed, costing one bubble. A valid HALT word ends the program.
//
// Ports
//   Clk          in   1     clock, rising edge
//   Rst_n        in   1     asynchronous active-low reset
//   Start        in   1     start at StartAddr (IDLE or DONE only)
//   StartAddr    in   PC_W  first instruction address
//   Stall        in   1     freeze all fetch state this cycle
//   ImemAddr     out  PC_W  ROM read address (= PC)
//   ImemData     in   9     ROM read data, one cycle after ImemAddr
//   Instruction  out  9     word for the decoder
//   InstrValid   out  1     Instruction is live (0 = bubble)
//   InstrPC      out  PC_W  address of the word on Instruction
//   BranchTaken  in   1     current valid Instruction is a taken branch
//   BranchIdx    in   4     offset LUT index of the branch
//   BranchDirWr  in   1     load the branch direction bit
//   BranchDirIn  in   1     0 = forward (+offset), 1 = backward (-offset)
//   Done         out  1     HALT reached; held until the next Start
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int         PC_W      = PC_W_DEFAULT,
  parameter logic [8:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Stall,
  output logic [PC_W-1:0] ImemAddr,
  input  logic [8:0]      ImemData,
  output logic [8:0]      Instruction,
  output logic            InstrValid,
  output logic [PC_W-1:0] InstrPC,
  input  logic            BranchTaken,
  input  logic [3:0]      BranchIdx,
  input  logic            BranchDirWr,
  input  logic            BranchDirIn,
  output logic            Done
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            dir_q, dir_d;

  // While stalled the ROM keeps reading the address *after* InstrPC, so the
  // word on Instruction is captured on the first stalled edge and replayed
  // until the stall is released.
  logic            held_q;
  logic [8:0]      hold_word_q;

  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] branch_target;
  logic            halt_seen;

  branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .idx_i    (BranchIdx),
    .offset_o (offset)
  );

  assign Instruction   = held_q ? hold_word_q : ImemData;
  assign halt_seen     = valid_q && (Instruction == HALT_WORD);
  // Modular arithmetic falls out of the PC_W-bit result width.
  assign branch_target = dir_q ? (instr_pc_q - offset) : (instr_pc_q + offset);

  // NOTE: every next-state signal is defaulted to its current value before any
  // branch of the logic below, so no path leaves a variable unassigned and no
  // latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    done_d     = done_q;
    dir_d      = dir_q;

    if (!Stall) begin
      // The branch in flight this cycle resolves with dir_q (the old value).
      if (BranchDirWr) begin
        dir_d = BranchDirIn;
      end

      unique case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            state_d = RUN;
            pc_d    = StartAddr;
            valid_d = 1'b0;
            done_d  = 1'b0;
            dir_d   = 1'b0;
          end
        end

        RUN: begin
          if (halt_seen) begin
            // HALT wins over a simultaneous taken branch; PC freezes.
            state_d = DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else if (valid_q && BranchTaken) begin
            // Squash the PC+1 word arriving next cycle.
            pc_d    = branch_target;
            valid_d = 1'b0;
          end else begin
            pc_d       = pc_q + PC_W'(1);
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of evaluation order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      held_q      <= 1'b0;
      hold_word_q <= '0;
    end else begin
      held_q <= Stall;
      if (Stall && !held_q) begin
        hold_word_q <= ImemData;
      end
    end
  end

  assign ImemAddr   = pc_q;
  assign InstrPC    = instr_pc_q;
  assign InstrValid = valid_q;
  assign Done       = done_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model tracks what the
//   fetch stage must present each cycle (program counter, delivered address,
//   valid/done) and a compare process checks the DUT against it on every
//   falling edge. Directed sequences pin the model with literal values, then
//   randomized stimulus exercises stalls, branches, direction writes, restarts
//   and resets. A second instance with a 4-bit PC covers PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int         PC_W  = 10;
  localparam int         DEPTH = 1 << PC_W;
  localparam logic [8:0] HALT  = 9'h1FF;

  // Expected branch offsets, index 0 first.
  int exp_lut [16] = '{1, 2, 6, 4, 8, 3, 16, 5, 32, 7, 12, 9, 64, 10, 100, 200};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            stall;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data;
  logic [8:0]      instr;
  logic            instr_valid;
  logic [PC_W-1:0] instr_pc;
  logic            br_taken;
  logic [3:0]      br_idx;
  logic            dir_wr;
  logic            dir_in;
  logic            done;

  logic [8:0]      rom [DEPTH];

  // Small instance: PC_W = 4
  logic            s_rst_n;
  logic            s_start;
  logic [3:0]      s_start_addr;
  logic [3:0]      s_imem_addr;
  logic [8:0]      s_imem_data;
  logic [8:0]      s_instr;
  logic            s_valid;
  logic [3:0]      s_ipc;
  logic            s_done;
  logic [8:0]      s_rom [16];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data   <= rom[imem_addr];
  always @(posedge clk) s_imem_data <= s_rom[s_imem_addr];

  fetch_unit #(
    .PC_W      (PC_W),
    .HALT_WORD (HALT)
  ) dut (
    .Clk         (clk),
    .Rst_n       (rst_n),
    .Start       (start),
    .StartAddr   (start_addr),
    .Stall       (stall),
    .ImemAddr    (imem_addr),
    .ImemData    (imem_data),
    .Instruction (instr),
    .InstrValid  (instr_valid),
    .InstrPC     (instr_pc),
    .BranchTaken (br_taken),
    .BranchIdx   (br_idx),
    .BranchDirWr (dir_wr),
    .BranchDirIn (dir_in),
    .Done        (done)
  );

  fetch_unit #(
    .PC_W      (4),
    .HALT_WORD (HALT)
  ) dut_small (
    .Clk         (clk),
    .Rst_n       (s_rst_n),
    .Start       (s_start),
    .StartAddr   (s_start_addr),
    .Stall       (1'b0),
    .ImemAddr    (s_imem_addr),
    .ImemData    (s_imem_data),
    .Instruction (s_instr),
    .InstrValid  (s_valid),
    .InstrPC     (s_ipc),
    .BranchTaken (1'b0),
    .BranchIdx   (4'd0),
    .BranchDirWr (1'b0),
    .BranchDirIn (1'b0),
    .Done        (s_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: "running" plus the address being fetched (m_pc), the
  // address whose word is being delivered (m_ipc) and whether it is live.
  // ---------------------------------------------------------------------------
  bit m_run, m_valid, m_done, m_dir;
  int m_pc, m_ipc;

  always @(posedge clk or negedge rst_n) begin : model
    int  n_pc, n_ipc, off;
    bit  n_run, n_valid, n_done, n_dir;
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_dir   <= 1'b0;
      m_pc    <= 0;
      m_ipc   <= 0;
    end else begin
      n_pc = m_pc; n_ipc = m_ipc; n_run = m_run;
      n_valid = m_valid; n_done = m_done; n_dir = m_dir;
      if (!stall) begin
        if (dir_wr) n_dir = dir_in;
        if (!m_run) begin
          if (start) begin
            n_run = 1'b1; n_pc = int'(start_addr);
            n_valid = 1'b0; n_done = 1'b0; n_dir = 1'b0;
          end
        end else if (m_valid && rom[m_ipc] == HALT) begin
          n_run = 1'b0; n_done = 1'b1; n_valid = 1'b0;
        end else if (m_valid && br_taken) begin
          off = m_dir ? -exp_lut[br_idx] : exp_lut[br_idx];
          n_pc = (m_ipc + off + DEPTH) % DEPTH;
          n_valid = 1'b0;
        end else begin
          n_ipc = m_pc;
          n_pc = (m_pc + 1) % DEPTH;
          n_valid = 1'b1;
        end
      end
      m_pc <= n_pc; m_ipc <= n_ipc; m_run <= n_run;
      m_valid <= n_valid; m_done <= n_done; m_dir <= n_dir;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", instr_valid, m_valid);
      check("m_done", done, m_done);
      check("m_imem_addr", imem_addr, m_pc);
      if (m_valid) begin
        check("m_instr_pc", instr_pc, m_ipc);
        check("m_instr", instr, rom[m_ipc]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; stall = 1'b0; br_taken = 1'b0;
    br_idx = 4'd0; dir_wr = 1'b0; dir_in = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must drop immediately.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, instr_valid, 0);
    check({tag, "_rst_done"}, done, 0);
    check({tag, "_rst_addr"}, imem_addr, 0);
    check({tag, "_rst_ipc"}, instr_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start(input int addr);
    start = 1'b1;
    start_addr = PC_W'(addr);
    tick();
    start = 1'b0;
  endtask

  task automatic expect_word(input string tag, input int pc, input logic [8:0] w);
    check({tag, "_valid"}, instr_valid, 1);
    check({tag, "_ipc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, w);
  endtask

  initial begin
    idle_inputs();
    start_addr = '0;
    rst_n = 1'b1; s_rst_n = 1'b1;
    s_start = 1'b0; s_start_addr = '0;

    for (int i = 0; i < DEPTH; i++) rom[i] = 9'($urandom_range(0, 9'h1FE));
    for (int i = 0; i < 4; i++) rom[5 + i] = 9'(9'h010 + i);
    rom[12]  = HALT;
    rom[300] = HALT;
    rom[700] = HALT;
    for (int i = 0; i < 16; i++) s_rom[i] = 9'(9'h040 + i);

    #1 rst_n = 1'b0; s_rst_n = 1'b0;
    #2;
    check("init_valid", instr_valid, 0);
    check("init_done", done, 0);
    check("init_addr", imem_addr, 0);
    check("init_ipc", instr_pc, 0);
    @(negedge clk);
    rst_n = 1'b1; s_rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();
    check("idle_valid", instr_valid, 0);

    // Start at 5: first word two edges after Start is sampled
    do_start(5);
    check("start_bubble", instr_valid, 0);
    check("start_addr", imem_addr, 5);
    tick(); expect_word("seq5", 5, 9'h010);
    tick(); expect_word("seq6", 6, 9'h011);
    tick(); expect_word("seq7", 7, 9'h012);
    // Start while running is ignored; stall holds everything
    start = 1'b1; start_addr = 10'd100; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_word("stall", 7, 9'h012);
      check("stall_addr", imem_addr, 8);
    end
    start = 1'b0; stall = 1'b0;
    tick(); expect_word("resume8", 8, 9'h013);

    // Forward branch at 10 with LUT[3]
    async_reset("fwd");
    do_start(10);
    tick(); expect_word("fwd10", 10, rom[10]);
    br_taken = 1'b1; br_idx = 4'd3;
    tick();
    br_taken = 1'b0;
    check("fwd_bubble", instr_valid, 0);
    check("fwd_target_addr", imem_addr, 14);
    tick(); expect_word("fwd14", 14, rom[14]);

    // Backward branch at 20 with LUT[2], then same-cycle DirWr uses old dir
    async_reset("bwd");
    do_start(20);
    dir_wr = 1'b1; dir_in = 1'b1;
    tick(); expect_word("bwd20", 20, rom[20]);
    dir_wr = 1'b0;
    br_taken = 1'b1; br_idx = 4'd2;
    tick();
    check("bwd_bubble", instr_valid, 0);
    tick(); expect_word("bwd14", 14, rom[14]);
    br_idx = 4'd3; dir_wr = 1'b1; dir_in = 1'b0;
    tick();
    br_taken = 1'b0; dir_wr = 1'b0;
    check("olddir_addr", imem_addr, 10);
    tick(); expect_word("olddir10", 10, rom[10]);
    br_taken = 1'b1; br_idx = 4'd0;
    tick();
    br_taken = 1'b0;
    check("newdir_addr", imem_addr, 11);

    // HALT at 12 together with a taken branch
    async_reset("halt");
    do_start(11);
    tick(); expect_word("halt11", 11, rom[11]);
    tick(); expect_word("halt12", 12, HALT);
    br_taken = 1'b1; br_idx = 4'd3;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("halt_done", done, 1);
      check("halt_valid", instr_valid, 0);
      check("halt_pc_frozen", imem_addr, 13);
      tick();
    end
    do_start(0);
    check("restart_done", done, 0);
    check("restart_valid", instr_valid, 0);
    tick(); expect_word("restart0", 0, rom[0]);

    // Wrap of the 10-bit PC
    async_reset("wrap");
    do_start(1022);
    tick(); expect_word("wrap1022", 1022, rom[1022]);
    tick(); expect_word("wrap1023", 1023, rom[1023]);
    tick(); expect_word("wrap0", 0, rom[0]);

    // Wrap of the 4-bit PC instance, then async reset mid-run
    s_start = 1'b1; s_start_addr = 4'd15;
    tick();
    s_start = 1'b0;
    check("s_start_addr", s_imem_addr, 15);
    tick();
    check("s_valid15", s_valid, 1);
    check("s_ipc15", s_ipc, 15);
    check("s_instr15", s_instr, 9'h04F);
    tick();
    check("s_ipc0", s_ipc, 0);
    check("s_instr0", s_instr, 9'h040);
    check("s_addr1", s_imem_addr, 1);
    #2 s_rst_n = 1'b0;
    #1;
    check("s_rst_valid", s_valid, 0);
    check("s_rst_ipc", s_ipc, 0);
    check("s_rst_addr", s_imem_addr, 0);
    check("s_rst_done", s_done, 0);
    @(negedge clk);
    s_rst_n = 1'b1;

    // Randomized phase
    async_reset("rand");
    for (int i = 0; i < 4000; i++) begin
      stall    = ($urandom_range(0, 4) == 0);
      br_taken = ($urandom_range(0, 3) == 0);
      br_idx   = 4'($urandom_range(0, 15));
      dir_wr   = ($urandom_range(0, 9) == 0);
      dir_in   = 1'($urandom_range(0, 1));
      start    = m_run ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 3) == 0);
      start_addr = PC_W'($urandom_range(0, DEPTH - 1));
      if (i % 1000 == 999) begin
        idle_inputs();
        async_reset("rand_mid");
      end else begin
        tick();
      end
    end
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
